// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bundle and
// the rule that decides whether an operation needs the iterative engine.
package seq_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic dz;
    } flags_t;

    // Division by zero is resolved in a single step, so it never starts the engine.
    function automatic logic needs_iter(input logic [OP_W-1:0] op, input logic b_zero);
        return (op == OP_MUL) || (!b_zero && ((op == OP_DIV) || (op == OP_MOD)));
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative engine: unsigned shift-add multiply and restoring divide, one step
// per clock for N clocks; results stay valid after the done pulse.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [OP_W-1:0] i_op,
    input  logic [N-1:0]    i_a,
    input  logic [N-1:0]    i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [2*N-1:0]  o_product,
    output logic [N-1:0]    o_quot,
    output logic [N-1:0]    o_rem
);

    logic             r_busy;
    logic             r_done;
    logic             r_is_mul;
    logic [CNT_W-1:0] r_cnt;

    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_div;

    logic [N:0]       w_shift;
    logic [N:0]       w_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_mul <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy   <= 1'b1;
                r_is_mul <= (i_op == OP_MUL);
                r_cnt    <= '0;
            end else if (r_busy) begin
                if (r_cnt == CNT_W'(N - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Partial remainder is always below the divisor, so the shifted value fits N+1 bits.
    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_rem    <= '0;
            r_quo    <= i_a;
            r_div    <= i_b;
        end else if (r_busy) begin
            if (r_is_mul) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end else begin
                r_rem <= w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];
                r_quo <= {r_quo[N-2:0], ~w_diff[N]};
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;
    assign o_quot    = r_quo;
    assign o_rem     = r_rem;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-step add/sub/logic/shift, iterative MUL/DIV/MOD,
// valid/ready on both sides, registered result and flags held until consumed.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  result,
    output logic            flag_z,
    output logic            flag_n,
    output logic            flag_c,
    output logic            flag_v,
    output logic            flag_dz
);

    state_e          r_state;
    state_e          w_state_nxt;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [OP_W-1:0] r_op;

    logic            r_vld_p0;
    logic [2*N-1:0]  r_res_p0;
    flags_t          r_flg_p0;

    logic [2*N-1:0]  r_result;
    flags_t          r_flg;

    logic            w_accept;
    logic            w_start;
    logic            w_load_p0;
    logic            w_b_zero;
    logic            w_eng_busy;
    logic            w_eng_done;
    logic [2*N-1:0]  w_prod;
    logic [N-1:0]    w_quot;
    logic [N-1:0]    w_rem;

    logic [N:0]      w_add;
    logic [N:0]      w_sub;
    logic [N:0]      w_shl;
    logic [2*N-1:0]  w_res;
    flags_t          w_flg;

    assign in_ready  = (r_state == IDLE) && !w_eng_busy;
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && needs_iter(op, b == '0);
    assign w_b_zero  = (r_b == '0);

    seq_alu_iter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (w_eng_busy),
        .o_done    (w_eng_done),
        .o_product (w_prod),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:       if (w_accept)  w_state_nxt = w_start ? ITER : EXEC;
            EXEC, ITER: if (r_vld_p0)  w_state_nxt = DONE;
            DONE:       if (out_ready) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} + {1'b0, ~r_b} + (N + 1)'(1);
    assign w_shl = {1'b0, r_a} << r_b;

    always_comb begin
        w_res = '0;
        w_flg = '0;
        case (r_op)
            OP_ADD: begin
                w_res[N-1:0] = w_add[N-1:0];
                w_flg.c      = w_add[N];
                w_flg.v      = (r_a[N-1] == r_b[N-1]) && (w_add[N-1] != r_a[N-1]);
            end
            OP_SUB: begin
                w_res[N-1:0] = w_sub[N-1:0];
                w_flg.c      = w_sub[N];
                w_flg.v      = (r_a[N-1] != r_b[N-1]) && (w_sub[N-1] != r_a[N-1]);
            end
            OP_MUL: w_res = w_prod;
            OP_DIV: begin
                w_res[N-1:0] = w_b_zero ? {N{1'b1}} : w_quot;
                w_flg.dz     = w_b_zero;
            end
            OP_MOD: begin
                w_res[N-1:0] = w_b_zero ? r_a : w_rem;
                w_flg.dz     = w_b_zero;
            end
            OP_AND: w_res[N-1:0] = r_a & r_b;
            OP_OR:  w_res[N-1:0] = r_a | r_b;
            OP_XOR: w_res[N-1:0] = r_a ^ r_b;
            // Shifting the extended operand puts the last bit out in bit N, including b==N.
            OP_SHL: begin
                if (r_b <= N'(N)) begin
                    w_res[N-1:0] = w_shl[N-1:0];
                    w_flg.c      = w_shl[N];
                end
            end
            OP_SHR: w_res[N-1:0] = r_a >> r_b;
            default: ;
        endcase
        if (r_op <= OP_SHR) begin
            w_flg.z = (r_op == OP_MUL) ? (w_res == '0) : (w_res[N-1:0] == '0);
            w_flg.n = (r_op == OP_MUL) ? w_res[2*N-1] : w_res[N-1];
        end
    end

    assign w_load_p0 = !r_vld_p0 &&
                       ((r_state == EXEC) || ((r_state == ITER) && w_eng_done));

    // Stage p0: operands latched at accept, datapath result captured once per request.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
        end
        if (w_load_p0) begin
            r_res_p0 <= w_res;
            r_flg_p0 <= w_flg;
        end
    end

    // Stage p1: output registers, loaded on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_result <= '0;
            r_flg    <= '0;
        end else begin
            r_vld_p0 <= w_load_p0;
            if (r_vld_p0) begin
                r_result <= r_res_p0;
                r_flg    <= r_flg_p0;
            end
        end
    end

    assign result  = r_result;
    assign flag_z  = r_flg.z;
    assign flag_n  = r_flg.n;
    assign flag_c  = r_flg.c;
    assign flag_v  = r_flg.v;
    assign flag_dz = r_flg.dz;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed N=4 scenarios plus an N=8 random regression.
module tb_seq_alu;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  fl;
        int          lat;
        int          op;
        int          a;
        int          b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, op4 = '0;
    logic [7:0] result4;
    logic       z4, n4, c4, v4, dz4;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] op8 = '0;
    logic [15:0] result8;
    logic       z8, n8, c8, v8, dz8;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q4[$];
    exp_t q8[$];

    seq_alu #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .flag_z(z4), .flag_n(n4), .flag_c(c4), .flag_v(v4), .flag_dz(dz4)
    );

    seq_alu #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8), .flag_dz(dz8)
    );

    // Reference: plain integer arithmetic, flags packed {z,n,c,v,dz}.
    function automatic exp_t model(input int w, input int op, input int a, input int b);
        exp_t e;
        int mask, half, sa, sb, r;
        logic z, n, c, v, dz;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - (1 << w) : a;
        sb = (b >= half) ? b - (1 << w) : b;
        r = 0; z = 0; n = 0; c = 0; v = 0; dz = 0;
        case (op)
            0: begin r = (a + b) & mask; c = (((a + b) >> w) & 1) != 0;
                     v = ((sa + sb) >= half) || ((sa + sb) < -half); end
            1: begin r = (a - b) & mask; c = (a >= b);
                     v = ((sa - sb) >= half) || ((sa - sb) < -half); end
            2: r = a * b;
            3: begin if (b == 0) begin r = mask; dz = 1; end else r = a / b; end
            4: begin if (b == 0) begin r = a; dz = 1; end else r = a % b; end
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: begin
                if (b < w) begin
                    r = (a << b) & mask;
                    c = (b == 0) ? 1'b0 : (((a >> (w - b)) & 1) != 0);
                end else if (b == w) begin
                    c = (a & 1) != 0;
                end
            end
            9: begin if (b < w) r = a >> b; end
            default: r = 0;
        endcase
        if (op <= 9) begin
            if (op == 2) begin
                z = (r == 0);
                n = ((r >> (2 * w - 1)) & 1) != 0;
            end else begin
                z = ((r & mask) == 0);
                n = ((r >> (w - 1)) & 1) != 0;
            end
        end
        e.res = r[15:0];
        e.fl  = {z, n, c, v, dz};
        e.lat = (op == 2 || ((op == 3 || op == 4) && b != 0)) ? w + 2 : 2;
        e.op = op; e.a = a; e.b = b;
        return e;
    endfunction

    task automatic send4(input int op, input int a, input int b);
        @(negedge clk);
        in_valid4 = 1'b1; op4 = op[3:0]; a4 = a[3:0]; b4 = b[3:0];
        q4.push_back(model(4, op, a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic collect4(output logic [7:0] r, output logic [4:0] f, output int lat, output bit ok);
        lat = 0;
        while (!out_valid4 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid4;
        r = result4;
        f = {z4, n4, c4, v4, dz4};
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic send8(input int op, input int a, input int b);
        @(negedge clk);
        in_valid8 = 1'b1; op8 = op[3:0]; a8 = a[7:0]; b8 = b[7:0];
        q8.push_back(model(8, op, a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic collect8(output logic [15:0] r, output logic [4:0] f, output int lat, output bit ok);
        lat = 0;
        while (!out_valid8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid8;
        r = result8;
        f = {z8, n8, c8, v8, dz8};
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({in_ready4, out_valid4, result4, z4, n4, c4, v4, dz4} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
            n_fail++;
            $display("FAIL reset4: rdy=%b vld=%b res=%h flags=%b, want rdy=1 vld=0 res=00 flags=00000",
                     in_ready4, out_valid4, result4, {z4, n4, c4, v4, dz4});
        end
        n_tests++;
        if ({in_ready8, out_valid8, result8, z8, n8, c8, v8, dz8} !== {1'b1, 1'b0, 16'h0000, 5'b0}) begin
            n_fail++;
            $display("FAIL reset8: rdy=%b vld=%b res=%h flags=%b, want rdy=1 vld=0 res=0000 flags=00000",
                     in_ready8, out_valid8, result8, {z8, n8, c8, v8, dz8});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int tbl[5][3] = '{'{0, 15, 8}, '{0, 7, 1}, '{1, 15, 15}, '{1, 0, 1}, '{1, 8, 1}};
        logic [7:0] r; logic [4:0] f; int lat; bit ok; exp_t e;
        for (int i = 0; i < 5; i++) begin
            send4(tbl[i][0], tbl[i][1], tbl[i][2]);
            collect4(r, f, lat, ok);
            e = q4.pop_front();
            n_tests++;
            if (!ok || r !== e.res[7:0] || f !== e.fl || lat != e.lat) begin
                n_fail++;
                $display("FAIL add_sub op=%0d a=%0d b=%0d: got res=%h zncvd=%b lat=%0d, want res=%h zncvd=%b lat=%0d",
                         e.op, e.a, e.b, r, f, lat, e.res[7:0], e.fl, e.lat);
            end
        end
    endtask

    task automatic test_mul_div();
        int tbl[9][3] = '{'{2, 9, 9}, '{2, 15, 15}, '{2, 0, 7}, '{3, 10, 2}, '{4, 10, 2},
                          '{3, 8, 0}, '{4, 8, 0}, '{3, 15, 4}, '{4, 13, 5}};
        logic [7:0] r; logic [4:0] f; int lat; bit ok; exp_t e;
        for (int i = 0; i < 9; i++) begin
            send4(tbl[i][0], tbl[i][1], tbl[i][2]);
            collect4(r, f, lat, ok);
            e = q4.pop_front();
            n_tests++;
            if (!ok || r !== e.res[7:0] || f !== e.fl || lat != e.lat) begin
                n_fail++;
                $display("FAIL mul_div op=%0d a=%0d b=%0d: got res=%h zncvd=%b lat=%0d, want res=%h zncvd=%b lat=%0d",
                         e.op, e.a, e.b, r, f, lat, e.res[7:0], e.fl, e.lat);
            end
        end
    endtask

    task automatic test_logic_shift();
        int tbl[12][3] = '{'{5, 12, 10}, '{6, 12, 10}, '{7, 12, 10}, '{8, 3, 1}, '{8, 9, 1}, '{8, 3, 4},
                           '{8, 3, 5}, '{9, 12, 2}, '{9, 12, 4}, '{10, 5, 3}, '{15, 0, 0}, '{12, 15, 15}};
        logic [7:0] r; logic [4:0] f; int lat; bit ok; exp_t e;
        for (int i = 0; i < 12; i++) begin
            send4(tbl[i][0], tbl[i][1], tbl[i][2]);
            collect4(r, f, lat, ok);
            e = q4.pop_front();
            n_tests++;
            if (!ok || r !== e.res[7:0] || f !== e.fl || lat != e.lat) begin
                n_fail++;
                $display("FAIL logic_shift op=%0d a=%0d b=%0d: got res=%h zncvd=%b lat=%0d, want res=%h zncvd=%b lat=%0d",
                         e.op, e.a, e.b, r, f, lat, e.res[7:0], e.fl, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        send4(0, 3, 4);
        e = q4.pop_front();
        lat = 0;
        while (!out_valid4 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (!out_valid4 || result4 !== e.res[7:0] || {z4, n4, c4, v4, dz4} !== e.fl) begin
            n_fail++;
            $display("FAIL backpressure_first: vld=%b res=%h zncvd=%b, want vld=1 res=%h zncvd=%b",
                     out_valid4, result4, {z4, n4, c4, v4, dz4}, e.res[7:0], e.fl);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 4'($urandom_range(0, 9));
            @(negedge clk);
            n_tests++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || result4 !== e.res[7:0] ||
                {z4, n4, c4, v4, dz4} !== e.fl) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d: vld=%b rdy=%b res=%h zncvd=%b, want vld=1 rdy=0 res=%h zncvd=%b",
                         i, out_valid4, in_ready4, result4, {z4, n4, c4, v4, dz4}, e.res[7:0], e.fl);
            end
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        n_tests++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_reaccept: rdy=%b vld=%b, want rdy=1 vld=0", in_ready4, out_valid4);
        end
        in_valid4 = 1'b0;
    endtask

    task automatic test_reset_mid_iter();
        logic [7:0] r; logic [4:0] f; int lat; bit ok; exp_t e;
        send4(2, 9, 9);
        void'(q4.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_iter_busy: rdy=%b vld=%b, want rdy=0 vld=0", in_ready4, out_valid4);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready4, out_valid4, result4, z4, n4, c4, v4, dz4} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
            n_fail++;
            $display("FAIL mid_iter_reset: rdy=%b vld=%b res=%h zncvd=%b, want rdy=1 vld=0 res=00 zncvd=00000",
                     in_ready4, out_valid4, result4, {z4, n4, c4, v4, dz4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send4(0, 5, 6);
        collect4(r, f, lat, ok);
        e = q4.pop_front();
        n_tests++;
        if (!ok || r !== e.res[7:0] || f !== e.fl || lat != e.lat) begin
            n_fail++;
            $display("FAIL after_reset_add: got res=%h zncvd=%b lat=%0d, want res=%h zncvd=%b lat=%0d",
                     r, f, lat, e.res[7:0], e.fl, e.lat);
        end
    endtask

    task automatic test_random8();
        int sh[4] = '{0, 7, 8, 255};
        int op, a, b;
        logic [15:0] r; logic [4:0] f; int lat; bit ok; exp_t e;
        for (int i = 0; i < 68; i++) begin
            a = $urandom_range(0, 255);
            if (i < 60) begin
                op = $urandom_range(0, 15);
                b  = (i % 7 == 0) ? 0 : $urandom_range(0, 255);
            end else begin
                op = (i % 2 == 0) ? 8 : 9;
                b  = sh[(i - 60) / 2];
            end
            send8(op, a, b);
            collect8(r, f, lat, ok);
            e = q8.pop_front();
            n_tests++;
            if (!ok || r !== e.res || f !== e.fl || lat != e.lat) begin
                n_fail++;
                $display("FAIL rand8 op=%0d a=%0d b=%0d: got res=%h zncvd=%b lat=%0d, want res=%h zncvd=%b lat=%0d",
                         e.op, e.a, e.b, r, f, lat, e.res, e.fl, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul_div();
        test_logic_shift();
        test_back_to_back();
        test_reset_mid_iter();
        test_random8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
